ysyx_25060170_regfile_mp: RTL

Parametrised multi-read-port general-purpose register file. It is the next-generation GPR for the NPC core.
- Configurable width, depth and read-port count.
- Optional write-to-read bypass and hardwired-zero entry 0.
- Per-register busy scoreboard for pending multi-cycle writebacks.
- Handshaked sequential dump port, so the difftest/trace logic can read the architectural state without simulation-only display code.

---
 rtl/ysyx_25060170_regfile_mp_if.sv | 33 +++
 rtl/ysyx_25060170_regfile_mp.sv | 103 ++++++++++
 2 files changed

// File: rtl/ysyx_25060170_regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write/mark port and dump stream.
// The core side drives through master; the register file sits on slave.
interface ysyx_25060170_regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NREAD  = 2
);
  logic [NREAD*ADDR_W-1:0] raddr;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [NREAD-1:0]        rbusy;
  logic                    we;
  logic [ADDR_W-1:0]       waddr;
  logic [DATA_W-1:0]       wdata;
  logic                    mark_we;
  logic [ADDR_W-1:0]       mark_addr;
  logic                    dump_start;
  logic                    dump_valid;
  logic                    dump_ready;
  logic [ADDR_W-1:0]       dump_idx;
  logic [DATA_W-1:0]       dump_data;
  logic                    dump_busy;
  logic                    dump_done;

  modport master (
    output raddr, we, waddr, wdata, mark_we, mark_addr, dump_start, dump_ready,
    input  rdata, rbusy, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );

  modport slave (
    input  raddr, we, waddr, wdata, mark_we, mark_addr, dump_start, dump_ready,
    output rdata, rbusy, dump_valid, dump_idx, dump_data, dump_busy, dump_done
  );
endinterface

// File: rtl/ysyx_25060170_regfile_mp.sv
// Multi-read-port GPR file with optional write bypass, hardwired x0, busy scoreboard
// and a handshaked sequential dump engine for trace/difftest.
module ysyx_25060170_regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_25060170_regfile_mp_if.slave bus
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {StIdle, StScan, StDone} dump_state_e;

  logic [DATA_W-1:0]       rf_q [DEPTH];
  logic [DEPTH-1:0]        busy_q, busy_d;
  dump_state_e             state_q, state_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic                    wr_en;
  logic [NREAD*DATA_W-1:0] rdata;
  logic [NREAD-1:0]        rbusy;

  // A write to a hardwired-zero entry is dropped everywhere, bypass included.
  assign wr_en = bus.we && !(ZERO_REG && (bus.waddr == '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q <= '{default: '0};
    end else if (wr_en) begin
      rf_q[bus.waddr] <= bus.wdata;
    end
  end

  // Mark is applied after the writeback clear so a same-cycle mark wins.
  always_comb begin
    busy_d = busy_q;
    if (bus.we) busy_d[bus.waddr] = 1'b0;
    if (bus.mark_we) busy_d[bus.mark_addr] = 1'b1;
    if (ZERO_REG) busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    logic              hit;
    assign ra      = bus.raddr[g*ADDR_W +: ADDR_W];
    assign is_zero = ZERO_REG && (ra == '0);
    assign hit     = BYPASS && wr_en && (bus.waddr == ra);
    assign rdata[g*DATA_W +: DATA_W] = is_zero ? '0 : (hit ? bus.wdata : rf_q[ra]);
    assign rbusy[g] = !hit && busy_q[ra];
  end

  assign bus.rdata = rdata;
  assign bus.rbusy = rbusy;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (bus.dump_start) begin
          state_d = StScan;
          idx_d   = '0;
        end
      end
      StScan: begin
        if (bus.dump_ready) begin
          idx_d = idx_q + 1'b1;
          if (&idx_q) state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.dump_valid = (state_q == StScan);
  assign bus.dump_busy  = (state_q != StIdle);
  assign bus.dump_done  = (state_q == StDone);
  assign bus.dump_idx   = idx_q;
  assign bus.dump_data  = (ZERO_REG && (idx_q == '0)) ? '0 : rf_q[idx_q];
endmodule
